// File: rtl/b_resp_router_2m.sv
// b_resp_router_2m: routes slave write responses back to the issuing master, in AW issue order.
module b_resp_router_2m #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             aw_accept,
    input  logic             aw_master,
    output logic             outstanding_full,
    output logic [CNT_W-1:0] outstanding_cnt,
    output logic             err_overflow,
    input  logic             M_AXI_bvalid,
    input  logic [1:0]       M_AXI_bresp,
    output logic             M_AXI_bready,
    output logic             S00_AXI_bvalid,
    output logic [1:0]       S00_AXI_bresp,
    input  logic             S00_AXI_bready,
    output logic             S01_AXI_bvalid,
    output logic [1:0]       S01_AXI_bresp,
    input  logic             S01_AXI_bready,
    output logic             Selected_Slave
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           state;
    logic [DEPTH-1:0] fifo;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       resp_q;
    logic             dest_q;
    logic             push, pop, release_hold;
    assign outstanding_full = count == CNT_W'(DEPTH);
    assign outstanding_cnt  = count + CNT_W'(state == HOLD);
    // bready only depends on registered state so a push cannot enable acceptance in its own cycle
    assign M_AXI_bready     = state == IDLE && count != '0;
    assign push             = aw_accept && !outstanding_full;
    assign pop              = M_AXI_bvalid && M_AXI_bready;
    assign release_hold     = dest_q ? S01_AXI_bready : S00_AXI_bready;
    assign S00_AXI_bvalid   = state == HOLD && !dest_q;
    assign S01_AXI_bvalid   = state == HOLD && dest_q;
    assign S00_AXI_bresp    = resp_q;
    assign S01_AXI_bresp    = resp_q;
    assign Selected_Slave   = dest_q;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            fifo         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            resp_q       <= 2'b00;
            dest_q       <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= aw_master;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (aw_accept && outstanding_full)
                err_overflow <= 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (state == IDLE) begin
                if (pop) begin
                    resp_q <= M_AXI_bresp;
                    dest_q <= fifo[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                    state  <= HOLD;
                end
            end else if (release_hold) begin
                state <= IDLE;
            end
        end
    end
endmodule
